// File: rtl/pc_fetch_unit.sv
// Program-counter fetch stage: issues word addresses to a 1-cycle-latency
// instruction memory and presents the returned instruction with its PC.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        fetch_fault
);

  localparam logic [31:0] LAST_ADDR = 32'(MEM_SIZE - 4);
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic        fault_q, fault_d;
  logic        hold_word;
  logic        issue;

  function automatic logic addr_legal(input logic [31:0] addr);
    return (addr[1:0] == 2'b00) && (addr <= LAST_ADDR);
  endfunction

  // A stalled valid instruction is re-read from memory so imem_instr stays stable.
  assign hold_word = (state_q != FAULT) && stall && instr_valid_q;
  assign issue     = redirect_valid || ((state_q != FAULT) && !hold_word);

  always_comb begin
    if (redirect_valid) begin
      imem_addr = redirect_target;
    end else if (hold_word) begin
      imem_addr = instr_pc_q;
    end else begin
      imem_addr = pc_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    fault_d       = fault_q;
    if (issue) begin
      if (addr_legal(imem_addr)) begin
        instr_pc_d    = imem_addr;
        instr_valid_d = 1'b1;
        pc_d          = imem_addr + 32'd4;
        state_d       = RUN;
        fault_d       = 1'b0;
      end else begin
        instr_valid_d = 1'b0;
        state_d       = FAULT;
        fault_d       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      instr_pc_q    <= 32'h0000_0000;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      fault_q       <= fault_d;
    end
  end

  assign instr_out   = instr_valid_q ? imem_instr : NOP_INSTR;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios followed by random stall/redirect/reset
// traffic, all compared against a cycle-level reference model of the fetch rules.
module tb_pc_fetch_unit;

  localparam int MEM = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr = 32'h0;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        fetch_fault;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_pc, m_ipc;
  logic        m_valid, m_fault;

  pc_fetch_unit #(.RESET_PC(32'h0), .MEM_SIZE(MEM)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .instr_out(instr_out), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
  endfunction

  // Instruction memory: word for the address seen at an edge appears after it.
  always @(posedge clk) imem_instr <= mem_word(imem_addr);

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (a < MEM);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".instr_pc"}, instr_pc, m_ipc);
    chk({tag, ".instr_valid"}, {31'b0, instr_valid}, {31'b0, m_valid});
    chk({tag, ".fetch_fault"}, {31'b0, fetch_fault}, {31'b0, m_fault});
    chk({tag, ".instr_out"}, instr_out, m_valid ? mem_word(m_ipc) : 32'h13);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_ipc = 32'h0; m_valid = 1'b0; m_fault = 1'b0;
  endtask

  // One clock: apply inputs, check the address, predict the edge, check outputs.
  task automatic step(input logic s, input logic rv, input logic [31:0] tgt);
    logic [31:0] ea;
    stall = s; redirect_valid = rv; redirect_target = tgt;
    #1;
    if (rv) ea = tgt;
    else if (!m_fault && s && m_valid) ea = m_ipc;
    else ea = m_pc;
    chk("imem_addr", imem_addr, ea);
    if (rv || (!m_fault && !(s && m_valid))) begin
      if (legal(ea)) begin
        m_ipc = ea; m_valid = 1'b1; m_pc = ea + 32'd4; m_fault = 1'b0;
      end else begin
        m_valid = 1'b0; m_fault = 1'b1;
      end
    end
    @(posedge clk); #1;
    check_outputs("step");
  endtask

  // Asynchronous reset asserted between edges, held across one edge, released.
  task automatic rst_pulse();
    redirect_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs("rst_async");
    chk("rst_async.imem_addr", imem_addr, 32'h0);
    @(posedge clk); #1;
    check_outputs("rst_held");
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] tgt;
    model_reset();
    #1;
    check_outputs("reset");
    chk("reset.imem_addr", imem_addr, 32'h0);
    @(posedge clk); #1;
    check_outputs("reset_edge");
    rst = 1'b0;

    // Sequential fetch from reset
    step(0, 0, 0); chk("seq.pc0", instr_pc, 32'h0); chk("seq.v0", {31'b0, instr_valid}, 32'h1);
    step(0, 0, 0); chk("seq.pc4", instr_pc, 32'h4);
    step(0, 0, 0); chk("seq.pc8", instr_pc, 32'h8);

    // Three-cycle stall holding instr_pc=8
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0);
      chk("stall.pc", instr_pc, 32'h8);
      chk("stall.out", instr_out, mem_word(32'h8));
    end
    step(0, 0, 0); chk("stall.release", instr_pc, 32'hC);
    step(0, 0, 0); chk("pc10", instr_pc, 32'h10);

    // Redirect overrides stall
    step(1, 1, 32'h40); chk("redir.pc40", instr_pc, 32'h40);
    chk("redir.valid", {31'b0, instr_valid}, 32'h1);
    step(0, 0, 0); chk("redir.pc44", instr_pc, 32'h44);

    // Misaligned redirect faults, then recovery
    step(0, 1, 32'h42);
    chk("mis.fault", {31'b0, fetch_fault}, 32'h1);
    chk("mis.valid", {31'b0, instr_valid}, 32'h0);
    chk("mis.out", instr_out, 32'h13);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("fault.sticky", {31'b0, fetch_fault}, 32'h1);
    step(0, 1, 32'hFFFF_FFFC);
    chk("oor.fault", {31'b0, fetch_fault}, 32'h1);
    step(0, 1, 32'h100);
    chk("recov.fault", {31'b0, fetch_fault}, 32'h0);
    chk("recov.pc", instr_pc, 32'h100);

    // Run off the end of memory
    step(0, 1, 32'h3F4);
    step(0, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0); chk("end.pc", instr_pc, 32'h3FC);
    step(0, 0, 0);
    chk("end.fault", {31'b0, fetch_fault}, 32'h1);
    chk("end.valid", {31'b0, instr_valid}, 32'h0);

    // Async reset during a stall at 0x20, then restart
    step(0, 1, 32'h20);
    step(1, 0, 0); chk("pre_rst.pc", instr_pc, 32'h20);
    rst_pulse();
    step(1, 0, 0); chk("restart.pc0", instr_pc, 32'h0);
    chk("restart.v", {31'b0, instr_valid}, 32'h1);
    step(0, 0, 0); chk("restart.pc4", instr_pc, 32'h4);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        rst_pulse();
      end else begin
        case ($urandom_range(0, 4))
          0: tgt = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
          1: tgt = {22'b0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
          2: tgt = 32'(MEM) + {$urandom_range(0, 64), 2'b00};
          3: tgt = 32'h3F0 + {$urandom_range(0, 3), 2'b00};
          default: tgt = $urandom;
        endcase
        step(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), tgt);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: byte address of the first fetch after reset.
REQ-002 Parameter MEM_SIZE, default 1024: instruction memory size in bytes; legal fetch addresses are word-aligned and <= MEM_SIZE-4.
REQ-003 clk  in  1: the single clock; all state updates on posedge.
REQ-004 rst  in  1: asynchronous, active-high reset.
REQ-005 stall  in  1: downstream is not accepting the presented instruction; hold it.
REQ-006 redirect_valid  in  1: a branch or jump is taken this cycle.
REQ-007 redirect_target  in  32: byte address of the taken branch or jump.
REQ-008 imem_addr  out  32: combinational byte address to the instruction memory, which returns data with 1 clk latency.
REQ-009 imem_instr  in  32: registered instruction-memory data for the address sampled at the previous edge.
REQ-010 instr_out  out  32: instruction presented downstream.
REQ-011 instr_pc  out  32: byte address of instr_out.
REQ-012 instr_valid  out  1: instr_out and instr_pc are valid.
REQ-013 fetch_fault  out  1: sticky misaligned or out-of-range fetch indication.

Function
REQ-014 Registers: pc (next address to issue), instr_pc, instr_valid, and state in {BOOT, RUN, FAULT}.
REQ-015 An address is legal iff addr[1:0]==2'b00 and addr <= MEM_SIZE-4.
REQ-016 imem_addr priority (combinational):
- redirect_valid -> redirect_target;
- else if stall and instr_valid -> instr_pc, so memory re-reads the held word;
- else -> pc.
REQ-017 instr_out = imem_instr when instr_valid, else 32'h0000_0013 (NOP).
REQ-018 Issue edge (any edge in BOOT or RUN, except stall with instr_valid and no redirect), if imem_addr is legal: instr_pc<=imem_addr, instr_valid<=1, pc<=imem_addr+4, state<=RUN.
REQ-019 Issue edge with illegal imem_addr: state<=FAULT, instr_valid<=0, fetch_fault<=1, pc and instr_pc hold.
REQ-020 Stall edge (stall=1, instr_valid=1, redirect_valid=0): pc, instr_pc, instr_valid and state all hold; instr_out is unchanged on the next cycle.
REQ-021 Redirect overrides stall; the instruction in flight is discarded with zero bubble, and the target instruction is valid the cycle after the redirect.
REQ-022 stall is ignored while instr_valid=0.
REQ-023 BOOT -> RUN (or FAULT) at the first edge after rst deasserts; stall is ignored in BOOT.
REQ-024 FAULT:
- imem_addr = pc, instr_valid=0;
- stall is ignored;
- a legal redirect performs an issue edge and returns to RUN with fetch_fault cleared to 0;
- an illegal redirect keeps FAULT.
REQ-025 No wrap-around: sequential fetch past MEM_SIZE-4 enters FAULT.
REQ-026 pc+4 is computed modulo 2^32; the overflow case is covered by REQ-025.

Reset
REQ-027 While rst=1, independent of clk: pc=RESET_PC, instr_pc=0, instr_valid=0, fetch_fault=0, state=BOOT, instr_out=32'h0000_0013, imem_addr=RESET_PC when redirect_valid=0.
REQ-028 rst asserted mid-stall or mid-redirect discards all in-flight state; the restart matches REQ-023.

Verification (MEM_SIZE=1024, RESET_PC=0)
REQ-029 Release rst, no stall -> cycle 1: instr_pc=0, instr_valid=1; cycle 2: instr_pc=4; imem_addr runs 0,4,8,12,... one cycle ahead of instr_pc.
REQ-030 stall=1 for 3 cycles while instr_pc=8 -> instr_pc=8, instr_out and instr_valid unchanged, imem_addr=8; on release, instr_pc=12 next cycle.
REQ-031 redirect_valid=1, target=0x40, with stall=1 while instr_pc=0x10 -> next cycle: instr_pc=0x40, instr_valid=1; following cycle: instr_pc=0x44.
REQ-032 Redirect to 0x42 -> next cycle: fetch_fault=1, instr_valid=0, instr_out=0x13; a later redirect to 0x100 -> fetch_fault=0, instr_pc=0x100.
REQ-033 Sequential run to instr_pc=0x3FC -> next edge: FAULT with fetch_fault=1; imem_addr is never 0x400 at an issue edge that sets instr_valid.
REQ-034 Assert rst asynchronously during a stall at instr_pc=0x20 -> outputs reach reset values before the next clk edge; the restart matches REQ-029.
